// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration loader and the CLB-side register decode:
// loader states, default sizes, sync preamble and the configuration word field layout.
package clb_cfg_pkg;

    localparam int         CFG_W  = 38;
    localparam int         ADDR_W = 8;
    localparam logic [7:0] SYNC   = 8'hB2;

    typedef enum logic [2:0] {
        S_HUNT,
        S_HDR,
        S_DATA,
        S_PAR,
        S_DONE,
        S_ERROR
    } state_t;

    // Field LSB positions inside a configuration word
    localparam int LUT_LSB         = 0;
    localparam int LUT_W           = 16;
    localparam int COMBO_LSB       = 16;
    localparam int COMBO_W         = 2;
    localparam int MUX_SEL_W       = 2;
    localparam int MUX2_LSB        = 18;
    localparam int MUX3_LSB        = 20;
    localparam int MUX4_LSB        = 22;
    localparam int MUX5_LSB        = 24;
    localparam int MUX6_LSB        = 26;
    localparam int O2M1_0_BIT      = 28;
    localparam int O2M2_0_BIT      = 29;
    localparam int O2M3_0_BIT      = 30;
    localparam int O2M1_1_BIT      = 31;
    localparam int O2M2_1_BIT      = 32;
    localparam int O2M3_1_BIT      = 33;
    localparam int DQMUX1_BIT      = 34;
    localparam int DQMUX2_BIT      = 35;
    localparam int FLOPORLATCH_BIT = 36;
    localparam int QINIT_BIT       = 37;

    function automatic logic [LUT_W-1:0] cfg_lut_mem(input logic [CFG_W-1:0] w);
        return w[LUT_LSB +: LUT_W];
    endfunction

    function automatic logic [COMBO_W-1:0] cfg_comboption(input logic [CFG_W-1:0] w);
        return w[COMBO_LSB +: COMBO_W];
    endfunction

    // Select field of mux n (2..6); the fields are packed contiguously from MUX2_LSB
    function automatic logic [MUX_SEL_W-1:0] cfg_mux_sel(input logic [CFG_W-1:0] w,
                                                         input int                n);
        return w[MUX2_LSB + MUX_SEL_W * (n - 2) +: MUX_SEL_W];
    endfunction

endpackage

// File: rtl/cfg_sync_detect.sv
// Preamble hunter: keeps the last seven accepted bits and flags when they plus the
// current bit equal the sync pattern, so the match is seen on the 8th bit itself.
module cfg_sync_detect #(
    parameter logic [7:0] PATTERN = clb_cfg_pkg::SYNC
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic match
);

    logic [6:0] win_p0;
    logic [7:0] win_nx;

    assign win_nx = {win_p0, din};
    assign match  = en && (win_nx == PATTERN);

    // The window is never cleared on a mismatch, so overlapping preambles are found
    always_ff @(posedge clk) begin
        if (rst) begin
            win_p0 <= '0;
        end else if (en) begin
            win_p0 <= win_nx[6:0];
        end
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// CLB configuration loader: finds the sync preamble in a serial stream, reads a frame
// count, then writes one even-parity-checked configuration word per CLB.
module clb_cfg_loader #(
    parameter int         CFG_W  = clb_cfg_pkg::CFG_W,
    parameter int         ADDR_W = clb_cfg_pkg::ADDR_W,
    parameter logic [7:0] SYNC   = clb_cfg_pkg::SYNC
) (
    input  logic              K,
    input  logic              RST,
    input  logic              DIN,
    input  logic              DVALID,
    output logic [CFG_W-1:0]  CFG_DATA,
    output logic [ADDR_W-1:0] CFG_ADDR,
    output logic              CFG_WE,
    output logic              DONE,
    output logic              ERR
);
    import clb_cfg_pkg::*;

    localparam int               CNT_W     = $clog2((CFG_W > ADDR_W) ? CFG_W : ADDR_W);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(CFG_W - 1);

    state_t state_q, state_nx;

    logic              sync_hit;
    logic [CNT_W-1:0]  cnt_p0;
    logic [ADDR_W-1:0] nfrm_p0;
    logic [ADDR_W-1:0] nfrm_shift;
    logic [CFG_W-1:0]  word_p0;
    logic              par_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              last_frm;

    logic              wr_ok;
    logic              done_d;
    logic              err_d;

    logic [CFG_W-1:0]  cfg_data_p1;
    logic [ADDR_W-1:0] cfg_addr_p1;
    logic              vld_p1;
    logic              done_p1;
    logic              err_p1;

    function automatic logic parity_ok(input logic acc, input logic pbit);
        return ~(acc ^ pbit);
    endfunction

    cfg_sync_detect #(
        .PATTERN(SYNC)
    ) u_sync (
        .clk  (K),
        .rst  (RST),
        .en   (DVALID && (state_q == S_HUNT)),
        .din  (DIN),
        .match(sync_hit)
    );

    assign nfrm_shift = {nfrm_p0[ADDR_W-2:0], DIN};
    assign last_frm   = ((addr_p0 + ADDR_W'(1)) == nfrm_p0);

    always_ff @(posedge K) begin
        if (RST) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_HUNT: begin
                if (sync_hit) state_nx = S_HDR;
            end
            S_HDR: begin
                if (DVALID && (cnt_p0 == HDR_LAST))
                    state_nx = (nfrm_shift == '0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
                if (DVALID && (cnt_p0 == DATA_LAST)) state_nx = S_PAR;
            end
            S_PAR: begin
                if (DVALID) begin
                    if (!parity_ok(par_p0, DIN)) state_nx = S_ERROR;
                    else if (last_frm)           state_nx = S_DONE;
                    else                         state_nx = S_DATA;
                end
            end
            S_DONE:  state_nx = S_DONE;
            S_ERROR: state_nx = S_ERROR;
            default: state_nx = S_HUNT;
        endcase
    end

    // After the last word, DONE follows the strobe cycle; an empty load raises it at once
    always_comb begin
        wr_ok  = 1'b0;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            S_HDR: begin
                done_d = (state_nx == S_DONE);
            end
            S_PAR: begin
                wr_ok = DVALID && parity_ok(par_p0, DIN);
                err_d = (state_nx == S_ERROR);
            end
            S_DONE:  done_d = 1'b1;
            S_ERROR: err_d  = 1'b1;
            default: begin
                wr_ok  = 1'b0;
                done_d = 1'b0;
                err_d  = 1'b0;
            end
        endcase
    end

    // ---- stage p0: header / word deserialisation, advances only on accepted bits ----
    always_ff @(posedge K) begin
        if (RST) begin
            cnt_p0  <= '0;
            nfrm_p0 <= '0;
            word_p0 <= '0;
            par_p0  <= 1'b0;
            addr_p0 <= '0;
        end else begin
            if (wr_ok) addr_p0 <= addr_p0 + ADDR_W'(1);
            if (DVALID) begin
                case (state_q)
                    S_HDR: begin
                        nfrm_p0 <= nfrm_shift;
                        cnt_p0  <= (cnt_p0 == HDR_LAST) ? '0 : cnt_p0 + CNT_W'(1);
                        par_p0  <= 1'b0;
                    end
                    S_DATA: begin
                        word_p0 <= {word_p0[CFG_W-2:0], DIN};
                        par_p0  <= par_p0 ^ DIN;
                        cnt_p0  <= (cnt_p0 == DATA_LAST) ? '0 : cnt_p0 + CNT_W'(1);
                    end
                    S_PAR: begin
                        par_p0 <= 1'b0;
                        cnt_p0 <= '0;
                    end
                    default: begin
                        cnt_p0 <= cnt_p0;
                    end
                endcase
            end
        end
    end

    // ---- stage p1: registered outputs; data/address hold between strobes ----
    always_ff @(posedge K) begin
        if (RST) begin
            cfg_data_p1 <= '0;
            cfg_addr_p1 <= '0;
            vld_p1      <= 1'b0;
            done_p1     <= 1'b0;
            err_p1      <= 1'b0;
        end else begin
            vld_p1  <= wr_ok;
            done_p1 <= done_d;
            err_p1  <= err_d;
            if (wr_ok) begin
                cfg_data_p1 <= word_p0;
                cfg_addr_p1 <= addr_p0;
            end
        end
    end

    assign CFG_DATA = cfg_data_p1;
    assign CFG_ADDR = cfg_addr_p1;
    assign CFG_WE   = vld_p1;
    assign DONE     = done_p1;
    assign ERR      = err_p1;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed bench for clb_cfg_loader: serial loads with hand-chosen words, stalls,
// parity failure, mid-load reset and post-DONE traffic.
module tb_clb_cfg_loader;

    localparam int         CFG_W    = 38;
    localparam int         ADDR_W   = 8;
    localparam logic [7:0] SYNC_PAT = 8'hB2;

    logic              K = 1'b0;
    logic              RST;
    logic              DIN;
    logic              DVALID;
    logic [CFG_W-1:0]  CFG_DATA;
    logic [ADDR_W-1:0] CFG_ADDR;
    logic              CFG_WE;
    logic              DONE;
    logic              ERR;

    clb_cfg_loader dut (
        .K       (K),
        .RST     (RST),
        .DIN     (DIN),
        .DVALID  (DVALID),
        .CFG_DATA(CFG_DATA),
        .CFG_ADDR(CFG_ADDR),
        .CFG_WE  (CFG_WE),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 K = ~K;

    int cyc = 0;
    always @(posedge K) cyc <= cyc + 1;

    int nvec  = 0;
    int nfail = 0;
    int stall_pct = 0;
    int last_edge = 0;

    // Strobe log: cycle stamp (posedge count), address and data of every CFG_WE cycle
    logic [CFG_W-1:0]  s_data[$];
    logic [ADDR_W-1:0] s_addr[$];
    int                s_cyc[$];

    always @(negedge K) begin
        if (CFG_WE === 1'b1) begin
            s_data.push_back(CFG_DATA);
            s_addr.push_back(CFG_ADDR);
            s_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        s_data.delete();
        s_addr.delete();
        s_cyc.delete();
    endtask

    // A driven bit is sampled at posedge number cyc+1
    task automatic send_bit(input logic b);
        while (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
            @(negedge K);
            DVALID = 1'b0;
            DIN    = 1'($urandom_range(0, 1));
        end
        @(negedge K);
        DIN       = b;
        DVALID    = 1'b1;
        last_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge K);
            DVALID = 1'b0;
            DIN    = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [CFG_W-1:0] w, input int nbits);
        for (int i = CFG_W - 1; i >= CFG_W - nbits; i--) send_bit(w[i]);
    endtask

    task automatic send_frame(input logic [CFG_W-1:0] w, input logic flip);
        send_word(w, CFG_W);
        send_bit((^w) ^ flip);
    endtask

    task automatic do_reset();
        @(negedge K);
        RST    = 1'b1;
        DVALID = 1'b0;
        DIN    = 1'b0;
        @(negedge K);
        RST = 1'b0;
        clear_log();
    endtask

    task automatic test_reset();
        RST    = 1'b1;
        DIN    = 1'b0;
        DVALID = 1'b0;
        repeat (3) @(negedge K);
        if (CFG_DATA !== '0) begin $display("FAIL reset_data: got %h want 0", CFG_DATA); nfail++; end
        nvec++;
        if (CFG_ADDR !== '0) begin $display("FAIL reset_addr: got %h want 0", CFG_ADDR); nfail++; end
        nvec++;
        if (CFG_WE !== 1'b0) begin $display("FAIL reset_we: got %b want 0", CFG_WE); nfail++; end
        nvec++;
        if (DONE !== 1'b0) begin $display("FAIL reset_done: got %b want 0", DONE); nfail++; end
        nvec++;
        if (ERR !== 1'b0) begin $display("FAIL reset_err: got %b want 0", ERR); nfail++; end
        nvec++;
        RST = 1'b0;
    endtask

    task automatic test_single();
        int pe;
        do_reset();
        stall_pct = 0;
        send_byte(SYNC_PAT);
        send_byte(8'h01);
        send_frame(38'h0000000116, 1'b0);
        pe = last_edge;
        @(negedge K);
        DVALID = 1'b0;
        if (CFG_WE !== 1'b1) begin $display("FAIL single_we: got %b want 1 at cycle %0d", CFG_WE, pe); nfail++; end
        nvec++;
        if (CFG_ADDR !== 8'h00) begin $display("FAIL single_addr: got %h want 00", CFG_ADDR); nfail++; end
        nvec++;
        if (CFG_DATA !== 38'h0000000116) begin $display("FAIL single_data: got %h want 0000000116", CFG_DATA); nfail++; end
        nvec++;
        @(negedge K);
        if (DONE !== 1'b1) begin $display("FAIL single_done: got %b want 1", DONE); nfail++; end
        nvec++;
        if (CFG_WE !== 1'b0) begin $display("FAIL single_we_drop: got %b want 0", CFG_WE); nfail++; end
        nvec++;
        idle(3);
        if (s_cyc.size() != 1) begin $display("FAIL single_nstrobe: got %0d want 1", s_cyc.size()); nfail++; end
        nvec++;
        if (ERR !== 1'b0) begin $display("FAIL single_err: got %b want 0", ERR); nfail++; end
        nvec++;
    endtask

    // Case 0: the given noise already ends in the preamble, so the header follows directly.
    // Case 1: the noise minus its last bit holds no preamble; an explicit SYNC follows.
    task automatic test_noise_hdr0();
        logic [10:0] nz;
        nz = 11'b10110110010;
        for (int c = 0; c < 2; c++) begin
            do_reset();
            stall_pct = 0;
            for (int i = 10; i >= c; i--) send_bit(nz[i]);
            if (c == 1) send_byte(SYNC_PAT);
            for (int i = 0; i < 7; i++) send_bit(1'b0);
            send_bit(1'b0);
            if (DONE !== 1'b0) begin $display("FAIL noise%0d_done_early: got %b want 0", c, DONE); nfail++; end
            nvec++;
            @(negedge K);
            DVALID = 1'b0;
            if (DONE !== 1'b1) begin $display("FAIL noise%0d_done: got %b want 1", c, DONE); nfail++; end
            nvec++;
            idle(3);
            if (s_cyc.size() != 0) begin $display("FAIL noise%0d_nstrobe: got %0d want 0", c, s_cyc.size()); nfail++; end
            nvec++;
            if (ERR !== 1'b0) begin $display("FAIL noise%0d_err: got %b want 0", c, ERR); nfail++; end
            nvec++;
        end
    endtask

    task automatic test_back_to_back();
        logic [CFG_W-1:0] w[3];
        int               pe[3];
        w[0] = 38'h2ADEADBEEF;
        w[1] = 38'h3FFFFFFFFF;
        w[2] = 38'h0000000001;
        do_reset();
        stall_pct = 30;
        send_byte(SYNC_PAT);
        send_byte(8'h03);
        for (int f = 0; f < 3; f++) begin
            send_frame(w[f], 1'b0);
            pe[f] = last_edge;
        end
        stall_pct = 0;
        idle(4);
        if (s_cyc.size() != 3) begin $display("FAIL b2b_nstrobe: got %0d want 3", s_cyc.size()); nfail++; end
        nvec++;
        for (int f = 0; f < 3; f++) begin
            if (f < s_cyc.size()) begin
                if (s_addr[f] !== ADDR_W'(f)) begin $display("FAIL b2b_addr%0d: got %h want %h", f, s_addr[f], ADDR_W'(f)); nfail++; end
                nvec++;
                if (s_data[f] !== w[f]) begin $display("FAIL b2b_data%0d: got %h want %h", f, s_data[f], w[f]); nfail++; end
                nvec++;
                if (s_cyc[f] != pe[f]) begin $display("FAIL b2b_lat%0d: got cycle %0d want %0d", f, s_cyc[f], pe[f]); nfail++; end
                nvec++;
            end
        end
        if (DONE !== 1'b1) begin $display("FAIL b2b_done: got %b want 1", DONE); nfail++; end
        nvec++;
        if (ERR !== 1'b0) begin $display("FAIL b2b_err: got %b want 0", ERR); nfail++; end
        nvec++;
    endtask

    task automatic test_parity_err();
        logic [CFG_W-1:0] w0, w1;
        w0 = 38'h0123456789;
        w1 = 38'h30F0F0F0F0;
        do_reset();
        stall_pct = 0;
        send_byte(SYNC_PAT);
        send_byte(8'h02);
        send_frame(w0, 1'b0);
        send_frame(w1, 1'b1);
        @(negedge K);
        DVALID = 1'b0;
        if (ERR !== 1'b1) begin $display("FAIL perr_err: got %b want 1", ERR); nfail++; end
        nvec++;
        if (CFG_WE !== 1'b0) begin $display("FAIL perr_we: got %b want 0", CFG_WE); nfail++; end
        nvec++;
        // Traffic after the error must be ignored
        send_byte(SYNC_PAT);
        send_byte(8'h01);
        send_frame(w1, 1'b0);
        idle(3);
        if (s_cyc.size() != 1) begin $display("FAIL perr_nstrobe: got %0d want 1", s_cyc.size()); nfail++; end
        nvec++;
        if (s_cyc.size() > 0) begin
            if (s_addr[0] !== 8'h00) begin $display("FAIL perr_addr: got %h want 00", s_addr[0]); nfail++; end
            nvec++;
        end
        if (ERR !== 1'b1) begin $display("FAIL perr_err_sticky: got %b want 1", ERR); nfail++; end
        nvec++;
        if (DONE !== 1'b0) begin $display("FAIL perr_done: got %b want 0", DONE); nfail++; end
        nvec++;
        if (CFG_DATA !== w0) begin $display("FAIL perr_data_hold: got %h want %h", CFG_DATA, w0); nfail++; end
        nvec++;
    endtask

    task automatic test_reset_mid_and_after_done();
        logic [CFG_W-1:0] wa, wb, wc, wd;
        wa = 38'h1111111111;
        wb = 38'h2222222222;
        wc = 38'h2468ACE013;
        wd = 38'h3C3C3C3C3C;
        do_reset();
        stall_pct = 0;
        send_byte(SYNC_PAT);
        send_byte(8'h02);
        send_frame(wa, 1'b0);
        send_word(wb, 20);
        @(negedge K);
        RST    = 1'b1;
        DIN    = 1'b1;
        DVALID = 1'b1;
        @(negedge K);
        RST    = 1'b0;
        DVALID = 1'b0;
        if (CFG_DATA !== '0) begin $display("FAIL mid_rst_data: got %h want 0", CFG_DATA); nfail++; end
        nvec++;
        if (CFG_ADDR !== '0) begin $display("FAIL mid_rst_addr: got %h want 0", CFG_ADDR); nfail++; end
        nvec++;
        if ({CFG_WE, DONE, ERR} !== 3'b000) begin $display("FAIL mid_rst_ctrl: got %b want 000", {CFG_WE, DONE, ERR}); nfail++; end
        nvec++;
        clear_log();
        send_byte(SYNC_PAT);
        send_byte(8'h01);
        send_frame(wc, 1'b0);
        @(negedge K);
        DVALID = 1'b0;
        if (CFG_WE !== 1'b1) begin $display("FAIL reload_we: got %b want 1", CFG_WE); nfail++; end
        nvec++;
        if (CFG_ADDR !== 8'h00) begin $display("FAIL reload_addr: got %h want 00", CFG_ADDR); nfail++; end
        nvec++;
        if (CFG_DATA !== wc) begin $display("FAIL reload_data: got %h want %h", CFG_DATA, wc); nfail++; end
        nvec++;
        idle(2);
        if (DONE !== 1'b1) begin $display("FAIL reload_done: got %b want 1", DONE); nfail++; end
        nvec++;
        // A second load after DONE must leave everything untouched
        clear_log();
        send_byte(SYNC_PAT);
        send_byte(8'h01);
        send_frame(wd, 1'b0);
        idle(3);
        if (s_cyc.size() != 0) begin $display("FAIL after_done_nstrobe: got %0d want 0", s_cyc.size()); nfail++; end
        nvec++;
        if (DONE !== 1'b1) begin $display("FAIL after_done_done: got %b want 1", DONE); nfail++; end
        nvec++;
        if (CFG_DATA !== wc) begin $display("FAIL after_done_data: got %h want %h", CFG_DATA, wc); nfail++; end
        nvec++;
        if (ERR !== 1'b0) begin $display("FAIL after_done_err: got %b want 0", ERR); nfail++; end
        nvec++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_noise_hdr0();
        test_back_to_back();
        test_parity_err();
        test_reset_mid_and_after_done();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
